// File: rtl/filt_cici_pkg.sv
// Width helpers shared by the CIC interpolator and its sub-module.
//   f_cici_int_width : internal datapath width, inp_w + N*clog2(R*M)
//   f_cici_oup_width : output width, internal width minus clog2(R)
package filt_cici_pkg;

  function automatic int unsigned f_cici_int_width(input int unsigned inp_w,
                                                    input int unsigned n,
                                                    input int unsigned r,
                                                    input int unsigned m);
    return inp_w + n * 32'($clog2(r * m));
  endfunction

  function automatic int unsigned f_cici_oup_width(input int unsigned inp_w,
                                                    input int unsigned n,
                                                    input int unsigned r,
                                                    input int unsigned m);
    return f_cici_int_width(inp_w, n, r, m) - 32'($clog2(r));
  endfunction

endpackage

// File: rtl/filt_cici_integ.sv
// Single enabled wrap-around accumulator used as one CIC integrator stage.
//   i_clk, i_rst_an : clock, async active-low reset
//   i_ena           : accumulate enable; state holds when low
//   i_data          : addend
//   o_acc           : registered accumulator value
module filt_cici_integ #(
  parameter int unsigned gp_width = 14
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_data,
  output logic [gp_width-1:0] o_acc
);

  logic [gp_width-1:0] acc_d;
  logic [gp_width-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (i_ena) begin
      acc_d = acc_q + i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/filt_cici.sv
// CIC interpolation filter: N low-rate combs, zero-stuffing by R, N full-rate
// integrators, all on one clock with a phase-counter sample strobe.
//   i_clk, i_rst_an : full-rate clock, async active-low reset
//   i_ena           : global enable; all state freezes when low
//   i_data          : signed low-rate sample, taken when o_rdy is high
//   o_rdy           : sample strobe, one cycle per R enabled cycles
//   o_data          : signed full-rate output (LSBs of the last integrator)
module filt_cici
  import filt_cici_pkg::*;
#(
  parameter int unsigned gp_interpolation_factor = 4,
  parameter int unsigned gp_order                = 3,
  parameter int unsigned gp_diff_delay           = 1,
  parameter int unsigned gp_phase                = 0,
  parameter int unsigned gp_inp_width            = 8,
  parameter int unsigned gp_oup_width            =
    f_cici_oup_width(gp_inp_width, gp_order, gp_interpolation_factor, gp_diff_delay)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_an,
  input  logic                    i_ena,
  input  logic [gp_inp_width-1:0] i_data,
  output logic                    o_rdy,
  output logic [gp_oup_width-1:0] o_data
);

  localparam int unsigned lp_w     =
    f_cici_int_width(gp_inp_width, gp_order, gp_interpolation_factor, gp_diff_delay);
  localparam int unsigned lp_cnt_w = $clog2(gp_interpolation_factor);
  localparam int unsigned lp_dly_w = gp_diff_delay * lp_w;

  logic [lp_cnt_w-1:0] cnt_d, cnt_q;
  logic                strobe;
  logic [lp_w-1:0]     comb_out;
  logic [lp_w-1:0]     r_up_d, r_up_q;
  logic                up_vld_d, up_vld_q;
  logic [lp_w-1:0]     up_in;
  logic [lp_w-1:0]     integ_last;

  // Strobe is gated by reset so it reads 0 while reset is held.
  assign strobe = i_rst_an && i_ena && (cnt_q == lp_cnt_w'(gp_phase));
  assign o_rdy  = strobe;

  // Phase counter, 0..R-1, advancing on enabled cycles only.
  always_comb begin
    cnt_d = cnt_q;
    if (i_ena) begin
      cnt_d = (cnt_q == lp_cnt_w'(gp_interpolation_factor - 1)) ? '0
                                                                 : cnt_q + lp_cnt_w'(1);
    end
  end

  // Comb chain, combinational at the low rate; each delay line shifts on the strobe.
  for (genvar k = 0; k < gp_order; k++) begin : g_comb
    logic [lp_w-1:0]                         x;
    logic [lp_w-1:0]                         y;
    logic [gp_diff_delay-1:0][lp_w-1:0]      dly_d, dly_q;

    if (k == 0) begin : g_src
      assign x = lp_w'($signed(i_data));
    end else begin : g_chain
      assign x = g_comb[k-1].y;
    end

    assign y = x - dly_q[gp_diff_delay-1];

    // Concatenate-and-truncate drops the oldest entry and inserts x at index 0.
    always_comb begin
      dly_d = dly_q;
      if (strobe) begin
        dly_d = lp_dly_w'({dly_q, x});
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        dly_q <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end
  end

  assign comb_out = g_comb[gp_order-1].y;

  // Upsampler register plus a flag marking the single enabled cycle it is consumed.
  always_comb begin
    r_up_d   = r_up_q;
    up_vld_d = up_vld_q;
    if (strobe) begin
      r_up_d = comb_out;
    end
    if (i_ena) begin
      up_vld_d = strobe;
    end
  end

  assign up_in = up_vld_q ? r_up_q : '0;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      cnt_q    <= '0;
      r_up_q   <= '0;
      up_vld_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      r_up_q   <= r_up_d;
      up_vld_q <= up_vld_d;
    end
  end

  // Pipelined integrator cascade at the full rate.
  for (genvar k = 0; k < gp_order; k++) begin : g_integ
    logic [lp_w-1:0] din;
    logic [lp_w-1:0] acc;

    if (k == 0) begin : g_first
      assign din = up_in;
    end else begin : g_next
      assign din = g_integ[k-1].acc;
    end

    filt_cici_integ #(
      .gp_width (lp_w)
    ) u_integ (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_ena    (i_ena),
      .i_data   (din),
      .o_acc    (acc)
    );
  end

  assign integ_last = g_integ[gp_order-1].acc;

  // Final value always fits the output width, so LSB truncation is exact.
  assign o_data = gp_oup_width'(integ_last);

endmodule

// File: tb/tb_filt_cici.sv
// Bench for filt_cici: three configurations (defaults, phase 2, R8/N4/M2)
// against an FIR-equivalent model h = (boxcar of length R*M)^N.
module tb_filt_cici;

  logic        clk = 1'b0;
  logic        rst_an = 1'b0;
  logic        ena_drv = 1'b0;
  logic [7:0]  data_drv = '0;
  int          sel = 0;

  logic        ena_a, ena_b, ena_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic [11:0] dout_a, dout_b;
  logic [20:0] dout_c;
  logic        obs_rdy;
  longint      obs_data;

  always #5 clk = ~clk;

  assign ena_a = ena_drv && (sel == 0);
  assign ena_b = ena_drv && (sel == 1);
  assign ena_c = ena_drv && (sel == 2);

  assign obs_rdy  = (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
  assign obs_data = (sel == 0) ? longint'($signed(dout_a)) :
                    (sel == 1) ? longint'($signed(dout_b)) : longint'($signed(dout_c));

  filt_cici u_dut_a (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena_a), .i_data(data_drv),
    .o_rdy(rdy_a), .o_data(dout_a)
  );

  filt_cici #(.gp_phase(2)) u_dut_b (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena_b), .i_data(data_drv),
    .o_rdy(rdy_b), .o_data(dout_b)
  );

  filt_cici #(.gp_interpolation_factor(8), .gp_order(4), .gp_diff_delay(2)) u_dut_c (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena_c), .i_data(data_drv),
    .o_rdy(rdy_c), .o_data(dout_c)
  );

  // Model state and scoreboard
  int       cur_r, cur_n, cur_m, cur_phase, cur_ow;
  int       model_cnt, e_idx, hlen;
  longint   h [256];
  longint   exp_acc [4096];
  longint   sb_q [$];
  logic     exp_rdy, got_rdy, got_en;
  longint   got_data;
  int       n_cmp = 0;
  int       n_fail = 0;

  task automatic model_init(input int r, input int n, input int m, input int ph, input int ow);
    longint tmp [256];
    cur_r = r; cur_n = n; cur_m = m; cur_phase = ph; cur_ow = ow;
    h[0] = 1;
    hlen = 1;
    for (int st = 0; st < n; st++) begin
      for (int i = 0; i < hlen + r * m - 1; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < r * m; j++)
          if (i - j >= 0 && i - j < hlen) tmp[i] += h[i - j];
      end
      hlen = hlen + r * m - 1;
      for (int i = 0; i < hlen; i++) h[i] = tmp[i];
    end
    for (int i = 0; i < 4096; i++) exp_acc[i] = 0;
    sb_q.delete();
    model_cnt = 0;
    e_idx = 0;
  endtask

  // Ends at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    ena_drv = 1'b0;
    data_drv = '0;
    rst_an = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_an = 1'b1;
  endtask

  // One clock: drive inputs, feed model, capture outputs mid-cycle, advance.
  task automatic step(input logic ena, input logic [7:0] x);
    logic   strobe;
    longint v;
    ena_drv = ena;
    data_drv = x;
    strobe = ena && (model_cnt == cur_phase);
    if (strobe)
      for (int k = 0; k < hlen; k++)
        exp_acc[e_idx + 1 + cur_n + k] += longint'($signed(x)) * h[k];
    exp_rdy = strobe;
    if (ena) begin
      v = exp_acc[e_idx];
      v = (v <<< (64 - cur_ow)) >>> (64 - cur_ow);
      sb_q.push_back(v);
    end
    #1;
    got_rdy = obs_rdy;
    got_data = obs_data;
    got_en = ena;
    if (ena) begin
      e_idx++;
      model_cnt = (model_cnt + 1) % cur_r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (dout_a !== '0) begin n_fail++; $display("FAIL reset_data_a got=%0d exp=0", dout_a); end
    if (dout_b !== '0) begin n_fail++; $display("FAIL reset_data_b got=%0d exp=0", dout_b); end
    if (dout_c !== '0) begin n_fail++; $display("FAIL reset_data_c got=%0d exp=0", dout_c); end
    if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_a got=%0b exp=0", rdy_a); end
    if (rdy_b !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_b got=%0b exp=0", rdy_b); end
    if (rdy_c !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_c got=%0b exp=0", rdy_c); end
  endtask

  task automatic test_impulse(input bit skip_reset);
    int     tbl [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    longint sum = 0;
    longint ev;
    longint want;
    sel = 0;
    if (!skip_reset) do_reset();
    model_init(4, 3, 1, 0, 12);
    for (int c = 0; c < 24; c++) begin
      step(1'b1, (c == 0) ? 8'd1 : 8'd0);
      n_cmp++;
      if (got_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL impulse_rdy cyc=%0d got=%0b exp=%0b", c, got_rdy, exp_rdy);
      end
      n_cmp++;
      ev = sb_q.pop_front();
      if (got_data !== ev) begin
        n_fail++; $display("FAIL impulse_sb cyc=%0d got=%0d exp=%0d", c, got_data, ev);
      end
      want = (c >= 4 && c < 14) ? longint'(tbl[c - 4]) : 0;
      n_cmp++;
      if (got_data !== want) begin
        n_fail++; $display("FAIL impulse_tap cyc=%0d got=%0d exp=%0d", c, got_data, want);
      end
      sum += got_data;
    end
    n_cmp++;
    if (sum !== 64) begin n_fail++; $display("FAIL impulse_sum got=%0d exp=64", sum); end
  endtask

  task automatic test_dc();
    int     lvl [2] = '{100, -128};
    longint ev;
    sel = 0;
    for (int l = 0; l < 2; l++) begin
      do_reset();
      model_init(4, 3, 1, 0, 12);
      for (int c = 0; c < 48; c++) begin
        step(1'b1, 8'(lvl[l]));
        n_cmp++;
        ev = sb_q.pop_front();
        if (got_data !== ev) begin
          n_fail++; $display("FAIL dc_sb lvl=%0d cyc=%0d got=%0d exp=%0d", lvl[l], c, got_data, ev);
        end
        if (c >= 16) begin
          n_cmp++;
          if (got_data !== longint'(16 * lvl[l])) begin
            n_fail++;
            $display("FAIL dc_settle lvl=%0d cyc=%0d got=%0d exp=%0d", lvl[l], c, got_data, 16 * lvl[l]);
          end
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    longint ev;
    sel = 0;
    do_reset();
    model_init(4, 3, 1, 0, 12);
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom));
      n_cmp++;
      if (got_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL gaps_rdy cyc=%0d en=%0b got=%0b exp=%0b", c, got_en, got_rdy, exp_rdy);
      end
      if (got_en) begin
        n_cmp++;
        ev = sb_q.pop_front();
        if (got_data !== ev) begin
          n_fail++; $display("FAIL gaps_sb cyc=%0d got=%0d exp=%0d", c, got_data, ev);
        end
      end
    end
  endtask

  task automatic test_phase();
    int     first = -1;
    int     en_cnt = 0;
    longint ev;
    sel = 1;
    do_reset();
    model_init(4, 3, 1, 2, 12);
    for (int c = 0; c < 160; c++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom));
      n_cmp++;
      if (got_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL phase_rdy cyc=%0d got=%0b exp=%0b", c, got_rdy, exp_rdy);
      end
      if (got_rdy === 1'b1 && first < 0) first = en_cnt;
      if (got_en) begin
        en_cnt++;
        n_cmp++;
        ev = sb_q.pop_front();
        if (got_data !== ev) begin
          n_fail++; $display("FAIL phase_sb cyc=%0d got=%0d exp=%0d", c, got_data, ev);
        end
      end
    end
    n_cmp++;
    if (first !== 2) begin n_fail++; $display("FAIL phase_first got=%0d exp=2", first); end
  endtask

  task automatic test_reset_mid();
    longint ev;
    sel = 0;
    do_reset();
    model_init(4, 3, 1, 0, 12);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, (c == 0) ? 8'd1 : 8'd0);
      n_cmp++;
      ev = sb_q.pop_front();
      if (got_data !== ev) begin
        n_fail++; $display("FAIL midrst_pre cyc=%0d got=%0d exp=%0d", c, got_data, ev);
      end
    end
    ena_drv = 1'b1;
    rst_an = 1'b0;
    #1;
    n_cmp += 2;
    if (obs_data !== 0) begin n_fail++; $display("FAIL midrst_data got=%0d exp=0", obs_data); end
    if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy got=%0b exp=0", obs_rdy); end
    repeat (2) @(posedge clk);
    #1 rst_an = 1'b1;
    test_impulse(1'b1);
  endtask

  task automatic test_sweep();
    logic [7:0] x;
    longint     ev;
    sel = 2;
    do_reset();
    model_init(8, 4, 2, 0, 21);
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 3))
        0:       x = 8'h80;
        1:       x = 8'h7f;
        default: x = 8'($urandom);
      endcase
      step($urandom_range(0, 9) < 9, x);
      n_cmp++;
      if (got_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL sweep_rdy cyc=%0d got=%0b exp=%0b", c, got_rdy, exp_rdy);
      end
      if (got_en) begin
        n_cmp++;
        ev = sb_q.pop_front();
        if (got_data !== ev) begin
          n_fail++; $display("FAIL sweep_sb cyc=%0d got=%0d exp=%0d", c, got_data, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse(1'b0);
    test_dc();
    test_enable_gaps();
    test_phase();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
